// File: rtl/txn_pkg.sv
// Shared encodings for the coin-transfer engine: FSM states, balance RAM map and status codes.
package txn_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        RK1   = 4'd1,
        RK2   = 4'd2,
        RB1   = 4'd3,
        RB2   = 4'd4,
        CHECK = 4'd5,
        WR_S  = 4'd6,
        WR_R  = 4'd7,
        DONE  = 4'd8,
        HOLD  = 4'd9
    } state_t;

    localparam logic [1:0] ADDR_BAL_P1 = 2'd0;
    localparam logic [1:0] ADDR_BAL_P2 = 2'd1;
    localparam logic [1:0] ADDR_KEY_P1 = 2'd2;
    localparam logic [1:0] ADDR_KEY_P2 = 2'd3;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_ERR_KEY   = 3'd1;
    localparam logic [2:0] ST_ERR_FUNDS = 3'd2;
    localparam logic [2:0] ST_ERR_OVF   = 3'd3;
    localparam logic [2:0] ST_ERR_ZERO  = 3'd4;

endpackage

// File: rtl/txn_check.sv
// Combinational validation of one transfer: picks the sender by key, checks funds and
// receiver overflow, and produces both post-transfer balances.
module txn_check
    import txn_pkg::*;
#(
    parameter int BAL_W = 8,
    parameter int KEY_W = 4
) (
    input  logic [BAL_W-1:0] amount,
    input  logic [KEY_W-1:0] key,
    input  logic [KEY_W-1:0] k1,
    input  logic [KEY_W-1:0] k2,
    input  logic [BAL_W-1:0] b1,
    input  logic [BAL_W-1:0] b2,
    output logic             sender,
    output logic [2:0]       status,
    output logic [BAL_W-1:0] new_sender_bal,
    output logic [BAL_W-1:0] new_receiver_bal
);

    logic             k1_match;
    logic             k2_match;
    logic [BAL_W-1:0] sender_bal;
    logic [BAL_W-1:0] receiver_bal;
    logic [BAL_W:0]   receiver_sum;

    always_comb begin
        k1_match         = (key == k1);
        k2_match         = (key == k2);
        // player 1 wins when both stored keys match
        sender           = !k1_match && k2_match;
        sender_bal       = sender ? b2 : b1;
        receiver_bal     = sender ? b1 : b2;
        receiver_sum     = {1'b0, receiver_bal} + {1'b0, amount};
        new_sender_bal   = sender_bal - amount;
        new_receiver_bal = receiver_sum[BAL_W-1:0];

        if (amount == '0)
            status = ST_ERR_ZERO;
        else if (!k1_match && !k2_match)
            status = ST_ERR_KEY;
        else if (amount > sender_bal)
            status = ST_ERR_FUNDS;
        else if (receiver_sum[BAL_W])
            status = ST_ERR_OVF;
        else
            status = ST_OK;
    end

endmodule

// File: rtl/transaction_engine.sv
// Runs one coin transfer between the two players against the shared single-port balance RAM.
//
// state | meaning
// IDLE  | waiting for start, latch amount/key
// RK1   | address key_p1
// RK2   | address key_p2, capture k1
// RB1   | address bal_p1, capture k2
// RB2   | address bal_p2, capture b1
// CHECK | capture b2, validate, record status
// WR_S  | write sender balance
// WR_R  | write receiver balance
// DONE  | finished pulse
// HOLD  | wait for start to drop
module transaction_engine
    import txn_pkg::*;
#(
    parameter int BAL_W = 8,
    parameter int KEY_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_transaction,
    input  logic [BAL_W-1:0] amount,
    input  logic [KEY_W-1:0] key,
    input  logic [BAL_W-1:0] mem_rdata,
    output logic [1:0]       mem_addr,
    output logic [BAL_W-1:0] mem_wdata,
    output logic             mem_we,
    output logic             finished_transaction,
    output logic [2:0]       status,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic [BAL_W-1:0] amount_q;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] k1_q;
    logic [KEY_W-1:0] k2_q;
    logic [BAL_W-1:0] b1_q;
    logic [BAL_W-1:0] b2_q;
    logic [BAL_W-1:0] b2_eval;
    logic [2:0]       status_q;
    logic [2:0]       chk_status;
    logic             sender;
    logic [BAL_W-1:0] new_sender_bal;
    logic [BAL_W-1:0] new_receiver_bal;

    // b2 arrives on the bus during CHECK; afterwards the captured copy keeps the writes stable
    assign b2_eval = (state == CHECK) ? mem_rdata : b2_q;

    txn_check #(
        .BAL_W(BAL_W),
        .KEY_W(KEY_W)
    ) u_check (
        .amount          (amount_q),
        .key             (key_q),
        .k1              (k1_q),
        .k2              (k2_q),
        .b1              (b1_q),
        .b2              (b2_eval),
        .sender          (sender),
        .status          (chk_status),
        .new_sender_bal  (new_sender_bal),
        .new_receiver_bal(new_receiver_bal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            amount_q <= '0;
            key_q    <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            b1_q     <= '0;
            b2_q     <= '0;
            status_q <= ST_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (start_transaction) begin
                        amount_q <= amount;
                        key_q    <= key;
                    end
                end
                RK2:   k1_q <= mem_rdata[KEY_W-1:0];
                RB1:   k2_q <= mem_rdata[KEY_W-1:0];
                RB2:   b1_q <= mem_rdata;
                CHECK: begin
                    b2_q     <= mem_rdata;
                    status_q <= chk_status;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_transaction) state_nxt = RK1;
            RK1:     state_nxt = RK2;
            RK2:     state_nxt = RB1;
            RB1:     state_nxt = RB2;
            RB2:     state_nxt = CHECK;
            CHECK:   state_nxt = (chk_status == ST_OK) ? WR_S : DONE;
            WR_S:    state_nxt = WR_R;
            WR_R:    state_nxt = DONE;
            DONE:    state_nxt = HOLD;
            HOLD:    if (!start_transaction) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr             = ADDR_BAL_P1;
        mem_wdata            = '0;
        mem_we               = 1'b0;
        finished_transaction = 1'b0;
        busy                 = (state != IDLE);
        case (state)
            RK1: mem_addr = ADDR_KEY_P1;
            RK2: mem_addr = ADDR_KEY_P2;
            RB1: mem_addr = ADDR_BAL_P1;
            RB2: mem_addr = ADDR_BAL_P2;
            WR_S: begin
                mem_we    = 1'b1;
                mem_addr  = sender ? ADDR_BAL_P2 : ADDR_BAL_P1;
                mem_wdata = new_sender_bal;
            end
            WR_R: begin
                mem_we    = 1'b1;
                mem_addr  = sender ? ADDR_BAL_P1 : ADDR_BAL_P2;
                mem_wdata = new_receiver_bal;
            end
            DONE: finished_transaction = 1'b1;
            default: ;
        endcase
    end

    assign status = status_q;

endmodule

// File: tb/tb_transaction_engine.sv
// Directed bench for transaction_engine with a behavioural RAM, a transfer-level model and a per-cycle compare.
module tb_transaction_engine;

    localparam int BAL_W   = 8;
    localparam int KEY_W   = 4;
    localparam int BAL_MAX = (1 << BAL_W) - 1;
    localparam int NONE    = -100;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_transaction = 1'b0;
    logic [BAL_W-1:0] amount = '0;
    logic [KEY_W-1:0] key = '0;
    logic [BAL_W-1:0] mem_rdata;
    logic [1:0]       mem_addr;
    logic [BAL_W-1:0] mem_wdata;
    logic             mem_we;
    logic             finished_transaction;
    logic [2:0]       status;
    logic             busy;

    transaction_engine #(.BAL_W(BAL_W), .KEY_W(KEY_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .start_transaction   (start_transaction),
        .amount              (amount),
        .key                 (key),
        .mem_rdata           (mem_rdata),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_we              (mem_we),
        .finished_transaction(finished_transaction),
        .status              (status),
        .busy                (busy)
    );

    always #5 clock = ~clock;

    // single-port RAM, one-cycle read latency
    logic [BAL_W-1:0] ram [4];
    logic [BAL_W-1:0] pl [4];
    logic             pl_en = 1'b0;

    always @(posedge clock) begin
        if (pl_en) begin
            for (int i = 0; i < 4; i++) ram[i] <= pl[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // expected RAM contents and the current transaction's schedule
    int mdl [4];
    int c0 = NONE, fin_cyc = NONE, ws_cyc = NONE, wr_cyc = NONE, busy_end = NONE;
    int exp_status = 0, prev_status = 0;
    int exp_s_addr = 0, exp_s_data = 0, exp_r_addr = 0, exp_r_data = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("mem_we", int'(mem_we), int'(cyc == ws_cyc || cyc == wr_cyc));
        if (cyc == ws_cyc) begin
            chk("sender_addr", int'(mem_addr), exp_s_addr);
            chk("sender_data", int'(mem_wdata), exp_s_data);
        end
        if (cyc == wr_cyc) begin
            chk("receiver_addr", int'(mem_addr), exp_r_addr);
            chk("receiver_data", int'(mem_wdata), exp_r_data);
        end
        if (cyc == c0)     chk("rd_addr_key_p1", int'(mem_addr), 2);
        if (cyc == c0 + 1) chk("rd_addr_key_p2", int'(mem_addr), 3);
        if (cyc == c0 + 2) chk("rd_addr_bal_p1", int'(mem_addr), 0);
        if (cyc == c0 + 3) chk("rd_addr_bal_p2", int'(mem_addr), 1);
        chk("finished", int'(finished_transaction), int'(cyc == fin_cyc));
        chk("busy", int'(busy), int'(cyc >= c0 && cyc <= busy_end));
        chk("status", int'(status), (cyc >= c0 + 5) ? exp_status : prev_status);
    end

    // transfer outcome from the rules, on plain integers
    task automatic model_txn(input int k, input int a, output int st, output int snd);
        int bal [2];
        bal[0] = mdl[0];
        bal[1] = mdl[1];
        snd = 0;
        st  = 0;
        if (a == 0) st = 4;
        else if (k == mdl[2] % (1 << KEY_W)) snd = 0;
        else if (k == mdl[3] % (1 << KEY_W)) snd = 1;
        else st = 1;
        if (st == 0) begin
            if (a > bal[snd]) st = 2;
            else if (bal[1 - snd] + a > BAL_MAX) st = 3;
        end
    endtask

    task automatic preload(input int b1, input int b2, input int k1, input int k2);
        @(posedge clock); #2;
        pl[0] = BAL_W'(b1); pl[1] = BAL_W'(b2); pl[2] = BAL_W'(k1); pl[3] = BAL_W'(k2);
        mdl[0] = b1; mdl[1] = b2; mdl[2] = k1; mdl[3] = k2;
        pl_en = 1'b1;
        @(posedge clock); #2;
        pl_en = 1'b0;
    endtask

    // start is sampled on the edge following the drive; expectations are anchored to that edge
    task automatic begin_txn(input int k, input int a, output int st, output int lat);
        int snd;
        @(posedge clock); #2;
        key = KEY_W'(k);
        amount = BAL_W'(a);
        start_transaction = 1'b1;
        @(posedge clock); #2;
        model_txn(k, a, st, snd);
        prev_status = exp_status;
        exp_status  = st;
        c0       = cyc;
        busy_end = 1000000;
        lat      = (st == 0) ? 7 : 5;
        fin_cyc  = c0 + lat;
        if (st == 0) begin
            ws_cyc     = c0 + 5;
            wr_cyc     = c0 + 6;
            exp_s_addr = snd;
            exp_s_data = mdl[snd] - a;
            exp_r_addr = 1 - snd;
            exp_r_data = mdl[1 - snd] + a;
        end else begin
            ws_cyc = NONE;
            wr_cyc = NONE;
        end
    endtask

    task automatic run_txn(input int k, input int a, input int hold);
        int st, lat;
        begin_txn(k, a, st, lat);
        repeat (lat + hold) @(posedge clock);
        #2;
        start_transaction = 1'b0;
        busy_end = cyc;
        @(posedge clock); #2;
        if (st == 0) begin
            mdl[exp_s_addr] = exp_s_data;
            mdl[exp_r_addr] = exp_r_data;
        end
        for (int i = 0; i < 4; i++) chk($sformatf("ram_%0d", i), int'(ram[i]), mdl[i]);
    endtask

    initial begin
        int st, lat;
        #2;
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_finished", int'(finished_transaction), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clock); #2;
        reset = 1'b0;

        // plain transfer p1 -> p2, start held long past completion
        preload(100, 50, 3, 9);
        run_txn(3, 30, 6);
        chk("t1_bal_p1", int'(ram[0]), 70);
        chk("t1_bal_p2", int'(ram[1]), 80);
        chk("t1_status", int'(status), 0);

        // insufficient funds, then exact balance
        preload(100, 50, 3, 9);
        run_txn(9, 60, 1);
        chk("t2a_status", int'(status), 2);
        run_txn(9, 50, 1);
        chk("t2b_bal_p1", int'(ram[0]), 150);
        chk("t2b_bal_p2", int'(ram[1]), 0);
        chk("t2b_status", int'(status), 0);

        // unknown key
        preload(100, 50, 3, 9);
        run_txn(5, 10, 2);
        chk("t3_status", int'(status), 1);
        chk("t3_bal_p1", int'(ram[0]), 100);
        chk("t3_bal_p2", int'(ram[1]), 50);

        // receiver overflow, then exact maximum
        preload(100, 250, 3, 9);
        run_txn(3, 10, 1);
        chk("t4a_status", int'(status), 3);
        run_txn(3, 5, 1);
        chk("t4b_bal_p1", int'(ram[0]), 95);
        chk("t4b_bal_p2", int'(ram[1]), 255);
        chk("t4b_status", int'(status), 0);

        // zero amount beats a valid key
        preload(100, 50, 3, 9);
        run_txn(3, 0, 1);
        chk("t5_status", int'(status), 4);

        // reset in the receiver-write cycle
        preload(100, 50, 3, 9);
        begin_txn(3, 30, st, lat);
        repeat (6) @(posedge clock);
        #2;
        chk("t6_in_wr_r_we", int'(mem_we), 1);
        c0 = NONE; fin_cyc = NONE; ws_cyc = NONE; wr_cyc = NONE; busy_end = NONE;
        exp_status = 0; prev_status = 0;
        #1 reset = 1'b1;
        #1;
        chk("t6_async_we", int'(mem_we), 0);
        chk("t6_async_addr", int'(mem_addr), 0);
        chk("t6_async_wdata", int'(mem_wdata), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_finished", int'(finished_transaction), 0);
        chk("t6_async_status", int'(status), 0);
        @(posedge clock); #2;
        reset = 1'b0;
        start_transaction = 1'b0;
        @(posedge clock); #2;
        chk("t6_bal_p1", int'(ram[0]), 70);
        chk("t6_bal_p2", int'(ram[1]), 50);
        mdl[0] = 70;
        mdl[1] = 50;
        run_txn(3, 30, 2);
        chk("t6b_bal_p1", int'(ram[0]), 40);
        chk("t6b_bal_p2", int'(ram[1]), 80);

        repeat (3) @(posedge clock);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
